// File: rtl/br_writeback.sv
// rtl/br_writeback.sv - write-back queue with youngest-match forwarding for a register bank
module br_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_data,
    input  logic                     hold,
    output logic [AW-1:0]            a3,
    output logic [DW-1:0]            wd3,
    output logic                     we,
    input  logic [AW-1:0]            q_a1,
    input  logic [AW-1:0]            q_a2,
    output logic                     pend1,
    output logic                     pend2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        req_ready = !full && !rst;
        we        = !empty && !hold;
        pop       = we;
        // x0 writes complete the handshake but never occupy an entry
        push      = req_valid && req_ready && (req_addr != '0);
        a3        = empty ? '0 : addr_q[rd_ptr_q];
        wd3       = empty ? '0 : data_q[rd_ptr_q];
        count     = count_q;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = req_addr;
            data_d[wr_ptr_q] = req_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last valid match is the youngest one
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        fwd1  = '0;
        fwd2  = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (q_a1 != '0 && addr_q[idx] == q_a1) begin
                    pend1 = 1'b1;
                    fwd1  = data_q[idx];
                end
                if (q_a2 != '0 && addr_q[idx] == q_a2) begin
                    pend2 = 1'b1;
                    fwd2  = data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_br_writeback.sv
// tb/tb_br_writeback.sv - randomized and directed bench for br_writeback against a queue model
module tb_br_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        hold = 1'b0;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we;
    logic [4:0]  q_a1 = '0;
    logic [4:0]  q_a2 = '0;
    logic        pend1, pend2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    logic [4:0]  m_addr [$];
    logic [31:0] m_data [$];
    logic [4:0]  dut_drain [$];

    br_writeback #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .hold(hold), .a3(a3), .wd3(wd3), .we(we),
        .q_a1(q_a1), .q_a2(q_a2),
        .pend1(pend1), .pend2(pend2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [4:0] qa, output logic p, output logic [31:0] f);
        p = 1'b0;
        f = '0;
        if (qa != 0) begin
            for (int i = m_addr.size() - 1; i >= 0; i--) begin
                if (m_addr[i] == qa) begin
                    p = 1'b1;
                    f = m_data[i];
                    break;
                end
            end
        end
    endtask

    // Entered just after a falling edge; leaves on the next falling edge.
    task automatic step(input logic v, input logic [4:0] ad, input logic [31:0] dt,
                        input logic h, input logic [4:0] a1, input logic [4:0] a2);
        logic        exp_ready, exp_we, p;
        logic [31:0] f;
        req_valid = v;
        req_addr  = ad;
        req_data  = dt;
        hold      = h;
        q_a1      = a1;
        q_a2      = a2;
        #1;
        exp_ready = (m_addr.size() < DEPTH);
        exp_we    = (m_addr.size() != 0) && !h;
        check("req_ready", req_ready, exp_ready);
        check("we", we, exp_we);
        check("count", count, m_addr.size());
        check("a3", a3, (m_addr.size() != 0) ? m_addr[0] : 5'd0);
        check("wd3", wd3, (m_data.size() != 0) ? m_data[0] : 32'd0);
        model_lookup(a1, p, f);
        check("pend1", pend1, p);
        check("fwd1", fwd1, f);
        model_lookup(a2, p, f);
        check("pend2", pend2, p);
        check("fwd2", fwd2, f);
        if (we) dut_drain.push_back(a3);
        @(posedge clk);
        if (exp_we) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
        end
        if (v && exp_ready && ad != 0) begin
            m_addr.push_back(ad);
            m_data.push_back(dt);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    initial begin
        logic [4:0] hist [$];

        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_we", we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);

        // single write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        idle_inputs();
        q_a1 = 5'd5;
        #1;
        check("single_we", we, 1'b1);
        check("single_a3", a3, 5'd5);
        check("single_wd3", wd3, 32'hDEADBEEF);
        check("single_pend1", pend1, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        check("single_we_after", we, 1'b0);
        check("single_count_after", count, 3'd0);

        // fill and backpressure
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'(i), 32'(i * 17), 1'b1, 5'(i), 5'd0);
        idle_inputs();
        #1;
        check("fill_count", count, 3'd4);
        check("fill_ready", req_ready, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 5'd4);
        dut_drain.delete();
        step(1'b1, 5'd5, 32'h55, 1'b0, 5'd5, 5'd1);
        step(1'b1, 5'd5, 32'h55, 1'b0, 5'd5, 5'd2);
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd3);
        check("drain_len", dut_drain.size(), 5);
        for (int i = 0; i < 5 && i < dut_drain.size(); i++)
            check("drain_order", dut_drain[i], 5'(i + 1));

        // youngest forwarding
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd3, 32'h2, 1'b1, 5'd0, 5'd0);
        step(1'b1, 5'd7, 32'h3, 1'b1, 5'd0, 5'd0);
        idle_inputs();
        q_a1 = 5'd7;
        q_a2 = 5'd3;
        #1;
        check("young_pend1", pend1, 1'b1);
        check("young_fwd1", fwd1, 32'h3);
        check("young_fwd2", fwd2, 32'h2);
        q_a1 = 5'd9;
        #1;
        check("miss_pend1", pend1, 1'b0);
        check("miss_fwd1", fwd1, 32'h0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd3);

        // x0 discard
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        idle_inputs();
        #1;
        check("x0_count", count, 3'd0);
        check("x0_we", we, 1'b0);
        check("x0_pend1", pend1, 1'b0);

        // wrap-around with simultaneous push/pop
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'd10, 5'd12);
            hist.push_back(5'(10 + i));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'(13 + i), 32'h200 + 32'(i), 1'b0, hist[hist.size() - 1], hist[hist.size() - 3]);
            hist.push_back(5'(13 + i));
            check("wrap_count", count, 3'd3);
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd21, 5'd22);

        // reset mid-drain
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(4 + i), 32'hA0 + 32'(i), 1'b1, 5'd0, 5'd0);
        idle_inputs();
        hold = 1'b0;
        q_a1 = 5'd4;
        #1;
        check("pre_rst_we", we, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", we, 1'b0);
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_pend1", pend1, 1'b0);
        check("mid_rst_ready", req_ready, 1'b0);
        m_addr.delete();
        m_data.delete();
        @(posedge clk);
        #1;
        check("mid_rst_we_after_edge", we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", req_ready, 1'b1);
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd4);
        idle_inputs();
        #1;
        check("rel_we", we, 1'b1);
        check("rel_a3", a3, 5'd9);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd0);

        // randomized traffic with address collisions
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_writeback.md
# br_writeback

Write-back queue and forwarding unit for the 32×32 register bank. Producers (ALU, load unit) hand results over a valid/ready handshake. The block buffers them in a small FIFO and drains at most one per cycle onto the bank's single write port (`a3`/`wd3`/`we`). For the two read addresses it reports whether a write is still pending and the youngest pending value, so the datapath can stall or forward.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, asynchronous and active-high.
- `req_valid`  in  1  producer has a write.
- `req_ready`  out  1  block can accept a write.
- `req_addr`  in  AW  destination register.
- `req_data`  in  DW  value to write.
- `hold`  in  1  bank write port unavailable; suppresses draining.
- `a3`  out  AW  bank write address (head entry).
- `wd3`  out  DW  bank write data (head entry).
- `we`  out  1  bank write enable.
- `q_a1`, `q_a2`  in  AW  read addresses to check.
- `pend1`, `pend2`  out  1  a queued write targets `q_a1` / `q_a2`.
- `fwd1`, `fwd2`  out  DW  data of the youngest queued entry matching `q_a1` / `q_a2`.
- `count`  out  clog2(DEPTH)+1  occupied entries.

## Operation
- FIFO: circular buffer with read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a `count` register.
  - `full` = (count == DEPTH).
  - `empty` = (count == 0).
- Handshake:
  - `req_ready` = !full. It does not depend on a same-cycle pop.
  - A transfer occurs on a rising edge with `req_valid && req_ready`.
  - `req_addr`/`req_data` are sampled at that edge.
  - With `req_valid` high and `req_ready` low, the producer holds its inputs stable; nothing is lost.
- x0 writes: a transfer with `req_addr == 0` completes the handshake but is discarded. It is never enqueued and never asserts `we`.
- Drain:
  - `a3`/`wd3` show the head entry combinationally.
  - `we` = !empty && !hold.
  - The head pops on each rising edge where `we` = 1.
  - When the queue is empty, `a3` and `wd3` are 0.
- Simultaneous push and pop:
  - Both take effect on the same edge and `count` is unchanged.
  - Allowed only when not full, because `req_ready` = !full.
- Forwarding:
  - For each port k, compare `q_ak` against every valid entry.
  - `pendk` = any match.
  - `fwdk` = data of the matching entry nearest the tail (youngest).
  - `fwdk` = 0 when there is no match.
  - `q_ak == 0` always gives `pendk` = 0 and `fwdk` = 0.
- Entry validity is derived from the pointers and `count`. Stale storage contents never match.
- Reset, asserted at any time including mid-drain:
  - Clears pointers and `count` immediately.
  - Queued writes are dropped.
  - Outputs while `rst` is high: `req_ready` = 0, `we` = 0, `a3` = 0, `wd3` = 0, `pend*` = 0, `fwd*` = 0, `count` = 0.
  - `req_ready` rises to 1 once `rst` falls.

## Timing
- Latency:
  - A write accepted at edge N into an empty queue, with `hold` low, shows `we` = 1 during cycle N→N+1.
  - The bank stores it at edge N+1.
  - `pend` is 1 for exactly that one cycle.
- Throughput: one accept and one drain per cycle.
  - With `hold` low, the queue never grows beyond 1.
  - While `hold` is high, it fills at one entry per accepted request.
- `pend*`, `fwd*`, `a3`, `wd3`, `we`, `req_ready` are combinational from state, `q_a*` and `hold`. They have no combinational path from `req_valid`/`req_addr`/`req_data`.
- On the edge where an entry is written to the bank, it leaves the queue. From the following cycle the bank itself provides that value, with no gap.

## Test plan
- Single write: reset, then push (addr 5, data 0xDEADBEEF), `hold` = 0.
  - Next cycle: `we` = 1, `a3` = 5, `wd3` = 0xDEADBEEF, `pend1` = 1 with `q_a1` = 5.
  - Cycle after: `we` = 0, `count` = 0.
- Fill and backpressure: `hold` = 1, push 4 writes (r1..r4 = 0x11..0x44).
  - `count` = 4, `req_ready` = 0; a 5th request held for 3 cycles is not lost.
  - Release `hold`: `we` pulses for 5 consecutive cycles in order r1, r2, r3, r4, r5.
- Youngest forwarding: `hold` = 1, push r7 = 0x1, r3 = 0x2, r7 = 0x3.
  - `q_a1` = 7 gives `pend1` = 1, `fwd1` = 0x3.
  - `q_a2` = 3 gives `fwd2` = 0x2.
  - `q_a1` = 9 gives `pend1` = 0, `fwd1` = 0.
- x0 discard: push (addr 0, data 0xFFFFFFFF) with `req_ready` = 1.
  - Handshake completes, `count` stays 0, `we` never asserts.
  - `q_a1` = 0 gives `pend1` = 0.
- Wrap-around with simultaneous push/pop:
  - Queue at 3 entries under `hold`; release `hold` and push every cycle for 10 cycles.
  - `count` stays 3, writes drain in FIFO order, pointers wrap.
  - `pend`/`fwd` stay correct across the wrap.
- Reset mid-operation: with 3 entries queued and `we` = 1, assert `rst` between edges.
  - `we`, `count`, `pend*` go to 0 immediately; no write occurs on the following edge.
  - After release, a new push drains normally.
